// File: rtl/format_change_notifier.sv
// Tracks the video format code across vsync edges, commits it once stable, and
// announces each committed change as a 16-bit {format, ~format} serial frame.
module format_change_notifier #(
    parameter int STABLE_FRAMES = 4,
    parameter int VS_TIMEOUT    = 2500000,
    parameter int SCLK_HALF     = 25,
    parameter int GAP_CYCLES    = 100
) (
    input  logic       clk,
    input  logic       reset_x,
    input  logic       vsync_in,
    input  logic [7:0] format_in,
    output logic [7:0] current_format,
    output logic       busy,
    output logic       ser_cs_n,
    output logic       ser_clk,
    output logic       ser_data
);

    localparam int SW = $clog2(STABLE_FRAMES + 1);
    localparam int TW = $clog2(VS_TIMEOUT + 1);
    localparam int HW = $clog2(SCLK_HALF + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_FRAMES);
    localparam logic [TW-1:0] TMO_MAX    = TW'(VS_TIMEOUT);
    localparam logic [HW-1:0] HALF_LAST  = HW'(SCLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT   = 4'd15;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

    // [0],[1] synchronise vsync_in, [2] holds the previous synchronised value
    logic [2:0]    vs_sync_reg;
    logic          vs_fall;

    logic [7:0]    candidate_reg;
    logic [SW-1:0] stable_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic [7:0]    current_format_reg;
    logic          pending_reg;
    logic          commit;
    logic          launch;

    tx_state_t     state_reg, state_next;
    logic [15:0]   tx_word_reg, tx_word_next;
    logic [HW-1:0] half_cnt_reg, half_cnt_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
    logic          cs_n_reg, cs_n_next;
    logic          sclk_reg, sclk_next;
    logic          data_reg, data_next;
    logic          half_done;
    logic          last_fall;
    logic          gap_done;

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            vs_sync_reg <= '1;
        end else begin
            vs_sync_reg <= {vs_sync_reg[1:0], vsync_in};
        end
    end

    assign vs_fall = vs_sync_reg[2] & ~vs_sync_reg[1];
    assign commit  = (stable_cnt_reg == STABLE_MAX) && (candidate_reg != current_format_reg);
    assign launch  = (state_reg == IDLE) && pending_reg;

    // A vsync edge always wins over the timeout; a saturated timeout keeps forcing 0x00.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            candidate_reg      <= '0;
            stable_cnt_reg     <= '0;
            tmo_cnt_reg        <= '0;
            current_format_reg <= '0;
            pending_reg        <= 1'b0;
        end else begin
            if (vs_fall) begin
                tmo_cnt_reg <= '0;
                if (format_in == candidate_reg) begin
                    if (stable_cnt_reg != STABLE_MAX) begin
                        stable_cnt_reg <= stable_cnt_reg + 1'b1;
                    end
                end else begin
                    candidate_reg  <= format_in;
                    stable_cnt_reg <= SW'(1);
                end
            end else if (tmo_cnt_reg != TMO_MAX) begin
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
            end else begin
                candidate_reg  <= '0;
                stable_cnt_reg <= STABLE_MAX;
            end

            if (commit) begin
                current_format_reg <= candidate_reg;
            end

            // A commit landing on the launch cycle still needs its own frame.
            if (commit) begin
                pending_reg <= 1'b1;
            end else if (launch) begin
                pending_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_reg    <= IDLE;
            tx_word_reg  <= '0;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            cs_n_reg     <= 1'b1;
            sclk_reg     <= 1'b0;
            data_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tx_word_reg  <= tx_word_next;
            half_cnt_reg <= half_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            cs_n_reg     <= cs_n_next;
            sclk_reg     <= sclk_next;
            data_reg     <= data_next;
        end
    end

    assign half_done = (half_cnt_reg == HALF_LAST);
    assign last_fall = half_done && sclk_reg && (bit_cnt_reg == LAST_BIT);
    assign gap_done  = (gap_cnt_reg == GAP_LAST);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pending_reg) state_next = SHIFT;
            SHIFT:   if (last_fall)   state_next = GAP;
            GAP:     if (gap_done)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_word_next  = tx_word_reg;
        half_cnt_next = half_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        cs_n_next     = cs_n_reg;
        sclk_next     = sclk_reg;
        data_next     = data_reg;
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    tx_word_next  = {current_format_reg, ~current_format_reg};
                    data_next     = current_format_reg[7];
                    cs_n_next     = 1'b0;
                    sclk_next     = 1'b0;
                    half_cnt_next = '0;
                    bit_cnt_next  = '0;
                end
            end
            SHIFT: begin
                if (half_done) begin
                    half_cnt_next = '0;
                    sclk_next     = ~sclk_reg;
                    // Data only moves on the falling toggle; the word rotates so bit 14 is next.
                    if (sclk_reg) begin
                        if (bit_cnt_reg == LAST_BIT) begin
                            cs_n_next    = 1'b1;
                            data_next    = 1'b0;
                            gap_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                            tx_word_next = {tx_word_reg[14:0], tx_word_reg[15]};
                            data_next    = tx_word_reg[14];
                        end
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + 1'b1;
                end
            end
            GAP: begin
                if (!gap_done) begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                cs_n_next = 1'b1;
                sclk_next = 1'b0;
                data_next = 1'b0;
            end
        endcase
    end

    assign current_format = current_format_reg;
    assign busy           = pending_reg | (state_reg != IDLE);
    assign ser_cs_n       = cs_n_reg;
    assign ser_clk        = sclk_reg;
    assign ser_data       = data_reg;

endmodule

// File: tb/tb_format_change_notifier.sv
// Directed bench: vsync edge tables for the stability filter plus hand sequences
// for timeout, back-to-back commits and mid-frame reset; frames are captured off the wire.
module tb_format_change_notifier;

    localparam int STABLE = 4;
    localparam int VS_TO  = 3000;
    localparam int HALF   = 25;
    localparam int GAP    = 100;

    logic       clk       = 1'b0;
    logic       reset_x   = 1'b1;
    logic       vsync_in  = 1'b1;
    logic [7:0] format_in = 8'h00;
    logic [7:0] current_format;
    logic       busy;
    logic       ser_cs_n;
    logic       ser_clk;
    logic       ser_data;

    always #5 clk = ~clk;

    format_change_notifier #(
        .STABLE_FRAMES(STABLE),
        .VS_TIMEOUT   (VS_TO),
        .SCLK_HALF    (HALF),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk           (clk),
        .reset_x       (reset_x),
        .vsync_in      (vsync_in),
        .format_in     (format_in),
        .current_format(current_format),
        .busy          (busy),
        .ser_cs_n      (ser_cs_n),
        .ser_clk       (ser_clk),
        .ser_data      (ser_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Wire-level frame capture: bits sampled on ser_clk rising, timing counted in clk cycles.
    logic        prev_cs   = 1'b1;
    logic        prev_sclk = 1'b0;
    int          cs_cnt    = 0;
    int          rise_cnt  = 0;
    int          first_rise = -1;
    int          last_rise_cyc = 0;
    logic [15:0] sh = '0;
    logic [15:0] frames_q[$];
    int          rises_q[$];
    int          len_q[$];
    int          first_q[$];

    always @(negedge clk) begin
        if (!ser_cs_n && prev_cs) begin
            cs_cnt = 0; rise_cnt = 0; first_rise = -1; sh = '0;
        end
        if (!ser_cs_n) begin
            if (ser_clk && !prev_sclk) begin
                if (rise_cnt == 0) first_rise = cs_cnt;
                sh = {sh[14:0], ser_data};
                rise_cnt++;
            end
            cs_cnt++;
        end
        if (ser_cs_n && !prev_cs) begin
            frames_q.push_back(sh);
            rises_q.push_back(rise_cnt);
            len_q.push_back(cs_cnt);
            first_q.push_back(first_rise);
            last_rise_cyc = cyc;
        end
        prev_cs   = ser_cs_n;
        prev_sclk = ser_clk;
    end

    typedef struct {
        logic [7:0] fmt;
        logic [7:0] exp_pre;
        logic [7:0] exp_post;
    } vec_t;
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One vsync falling edge; pre is sampled the cycle before a commit could land, post the cycle after.
    task automatic vs_edge(input logic [7:0] fmt, output logic [7:0] pre, output logic [7:0] post);
        @(negedge clk);
        format_in = fmt;
        @(negedge clk);
        vsync_in = 1'b0;
        fall_cyc = cyc;
        repeat (3) @(negedge clk);
        pre = current_format;
        @(negedge clk);
        post = current_format;
        vsync_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_rows(input int lo, input int hi);
        logic [7:0] pre, post;
        for (int i = lo; i <= hi; i++) begin
            vs_edge(vecs[i].fmt, pre, post);
            $display("edge %0d fmt=%02h current %02h -> %02h busy=%0b", i, vecs[i].fmt, pre, post, busy);
            check($sformatf("row%0d_pre", i), {24'h0, pre}, {24'h0, vecs[i].exp_pre});
            check($sformatf("row%0d_post", i), {24'h0, post}, {24'h0, vecs[i].exp_post});
        end
    endtask

    task automatic edges(input logic [7:0] fmt, input int n, input string name);
        logic [7:0] pre, post;
        for (int i = 0; i < n; i++) begin
            vs_edge(fmt, pre, post);
            $display("edge %s fmt=%02h current %02h -> %02h busy=%0b", name, fmt, pre, post, busy);
        end
        check({name, "_commit"}, {24'h0, post}, {24'h0, fmt});
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
        check({name, "_idle"}, {31'h0, busy}, 32'h0);
    endtask

    task automatic expect_frame(input string name, input logic [15:0] exp);
        check({name, "_present"}, (frames_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (frames_q.size() > 0) begin
            $display("frame %s word=%04h rises=%0d cs_low=%0d first=%0d",
                     name, frames_q[0], rises_q[0], len_q[0], first_q[0]);
            check({name, "_word"}, {16'h0, frames_q.pop_front()}, {16'h0, exp});
            check({name, "_rises"}, rises_q.pop_front(), 32'd16);
            check({name, "_cs_low"}, len_q.pop_front(), 32'(32 * HALF));
            check({name, "_first_sclk"}, first_q.pop_front(), 32'(HALF));
        end
    endtask

    task automatic check_none(input string name);
        check({name, "_no_extra_frame"}, frames_q.size(), 32'd0);
    endtask

    task automatic check_idle_pins(input string name);
        check({name, "_cs_n"}, {31'h0, ser_cs_n}, 32'd1);
        check({name, "_sclk"}, {31'h0, ser_clk}, 32'd0);
        check({name, "_data"}, {31'h0, ser_data}, 32'd0);
    endtask

    initial begin
        int n;
        logic [7:0] pre, post;

        // Stability filter from reset, including an interrupting 0x03 and an unchanged recommit.
        vecs[0]  = '{8'h01, 8'h00, 8'h00};
        vecs[1]  = '{8'h01, 8'h00, 8'h00};
        vecs[2]  = '{8'h03, 8'h00, 8'h00};
        vecs[3]  = '{8'h01, 8'h00, 8'h00};
        vecs[4]  = '{8'h01, 8'h00, 8'h00};
        vecs[5]  = '{8'h01, 8'h00, 8'h00};
        vecs[6]  = '{8'h01, 8'h00, 8'h01};
        vecs[7]  = '{8'h01, 8'h01, 8'h01};
        // Three commits in quick succession: 0x02, 0x0C, 0x13.
        vecs[8]  = '{8'h02, 8'h01, 8'h01};
        vecs[9]  = '{8'h02, 8'h01, 8'h01};
        vecs[10] = '{8'h02, 8'h01, 8'h01};
        vecs[11] = '{8'h02, 8'h01, 8'h02};
        vecs[12] = '{8'h0C, 8'h02, 8'h02};
        vecs[13] = '{8'h0C, 8'h02, 8'h02};
        vecs[14] = '{8'h0C, 8'h02, 8'h02};
        vecs[15] = '{8'h0C, 8'h02, 8'h0C};
        vecs[16] = '{8'h13, 8'h0C, 8'h0C};
        vecs[17] = '{8'h13, 8'h0C, 8'h0C};
        vecs[18] = '{8'h13, 8'h0C, 8'h0C};
        vecs[19] = '{8'h13, 8'h0C, 8'h13};

        #1 reset_x = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_current", {24'h0, current_format}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check_idle_pins("rst");
        reset_x = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_current", {24'h0, current_format}, 32'h0);

        // Stability filter and first frame
        run_rows(0, 7);
        wait_idle("a");
        check("a_gap", cyc - last_rise_cyc, 32'(GAP));
        expect_frame("a_frame", 16'h01FE);
        check_none("a");
        check_idle_pins("a_end");

        // Commits during a frame collapse into one follow-up frame
        run_rows(8, 19);
        wait_idle("b");
        check("b_gap", cyc - last_rise_cyc, 32'(GAP));
        expect_frame("b_frame1", 16'h02FD);
        expect_frame("b_frame2", 16'h13EC);
        check_none("b");

        // Unchanged recommit must stay silent
        edges(8'h0B, STABLE, "c");
        wait_idle("c");
        expect_frame("c_frame", 16'h0BF4);
        for (int i = 0; i < 5; i++) begin
            vs_edge(8'h0B, pre, post);
            $display("edge c_hold fmt=0b current %02h -> %02h busy=%0b", pre, post, busy);
            check($sformatf("c_hold%0d_current", i), {24'h0, post}, 32'h0B);
            check($sformatf("c_hold%0d_busy", i), {31'h0, busy}, 32'h0);
        end
        check_none("c");

        // vsync stuck high forces 0x00
        edges(8'h04, STABLE, "d");
        wait_idle("d");
        expect_frame("d_frame", 16'h04FB);
        check("d_before_timeout", {24'h0, current_format}, 32'h04);
        n = 0;
        while (current_format != 8'h00 && n < VS_TO + 100) begin
            @(negedge clk);
            n++;
        end
        $display("timeout: current=%02h after %0d cycles from vsync fall", current_format, cyc - fall_cyc);
        check("d_timeout_latency", cyc - fall_cyc, 32'(VS_TO + 5));
        check("d_timeout_current", {24'h0, current_format}, 32'h0);
        wait_idle("d2");
        expect_frame("d_frame0", 16'h00FF);
        check_none("d");

        // Reset in the middle of a frame
        edges(8'h05, STABLE, "e");
        n = 0;
        while (ser_cs_n && n < 50) begin @(negedge clk); n++; end
        check("e_frame_started", {31'h0, ser_cs_n}, 32'd0);
        n = 0;
        while (rise_cnt < 7 && n < 1000) begin @(negedge clk); n++; end
        check("e_bit7", rise_cnt, 32'd7);
        #2 reset_x = 1'b0;
        #1;
        $display("reset mid-frame: cs_n=%0b sclk=%0b data=%0b busy=%0b current=%02h",
                 ser_cs_n, ser_clk, ser_data, busy, current_format);
        check_idle_pins("e_rst");
        check("e_rst_busy", {31'h0, busy}, 32'h0);
        check("e_rst_current", {24'h0, current_format}, 32'h0);
        repeat (3) @(negedge clk);
        reset_x = 1'b1;
        frames_q.delete();
        rises_q.delete();
        len_q.delete();
        first_q.delete();
        repeat (1200) @(negedge clk);
        check_none("e_after_rst");
        check("e_after_rst_busy", {31'h0, busy}, 32'h0);
        check_idle_pins("e_after_rst");

        // A fresh commit after reset sends again
        edges(8'h06, STABLE, "f");
        wait_idle("f");
        expect_frame("f_frame", 16'h06F9);
        check_none("f");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/format_change_notifier.md
FORMAT_CHANGE_NOTIFIER -- requirements
Module: format_change_notifier

Interface
REQ-001 Parameter STABLE_FRAMES, default 4: consecutive vsync falling edges with identical format_in required before commit.
REQ-002 Parameter VS_TIMEOUT, default 2500000: clk cycles without a vsync falling edge before forcing format 0x00.
REQ-003 Parameter SCLK_HALF, default 25: clk cycles per ser_clk half-period.
REQ-004 Parameter GAP_CYCLES, default 100: clk cycles ser_cs_n stays high after each frame.
REQ-005 clk  in  1  block clock.
REQ-006 reset_x  in  1  reset, asynchronous, active-low.
REQ-007 vsync_in  in  1  filtered vsync, asynchronous to clk.
REQ-008 format_in  in  8  format code from the video format detector; quasi-static.
REQ-009 current_format  out  8  last committed format.
REQ-010 busy  out  1  high while a frame is being sent or a send is pending.
REQ-011 ser_cs_n  out  1  serial frame select, active-low.
REQ-012 ser_clk  out  1  serial clock, idle low.
REQ-013 ser_data  out  1  serial data, MSB first.

Function
REQ-014 vsync_in passes through a 2-flop synchroniser plus 1 history flop; vs_fall is a 1-cycle pulse on a synchronised 1->0 transition.
REQ-015 On vs_fall: if format_in == candidate, stable_cnt increments, saturating at STABLE_FRAMES; otherwise candidate <= format_in and stable_cnt <= 1.
REQ-016 Commit happens when stable_cnt == STABLE_FRAMES and candidate != current_format: current_format <= candidate next cycle, pending <= 1.
REQ-017 Recommitting an unchanged value sets no pending flag and sends no frame.
REQ-018 Timeout counter clears on every vs_fall and increments otherwise, saturating at VS_TIMEOUT.
REQ-019 When the timeout counter reaches VS_TIMEOUT: candidate <= 0x00 and stable_cnt <= STABLE_FRAMES, so 0x00 commits via REQ-016 if current_format != 0x00.
REQ-020 A vs_fall in the same cycle as the timeout takes priority over the timeout.
REQ-021 TX FSM states: IDLE, SHIFT, GAP.
REQ-022 IDLE, pending == 1: latch tx_word = {current_format, ~current_format} (16 bits), clear pending, drive ser_cs_n low, drive ser_data = tx_word[15], go to SHIFT.
REQ-023 SHIFT: ser_clk toggles every SCLK_HALF cycles; the first toggle comes SCLK_HALF cycles after ser_cs_n falls.
REQ-024 SHIFT: ser_data changes only on ser_clk falling edges, so it is stable at each rising edge.
REQ-025 SHIFT: exactly 16 rising edges; after the 16th falling edge ser_cs_n goes high, ser_clk stays low and ser_data goes 0; then GAP.
REQ-026 GAP: hold for GAP_CYCLES, then IDLE.
REQ-027 A commit during SHIFT or GAP sets pending and does not abort the current frame; the next frame carries current_format as latched at entry to IDLE.
REQ-028 Several commits during one frame produce one following frame carrying the latest value.
REQ-029 busy = pending OR (state != IDLE).

Reset
REQ-030 While reset_x is low: current_format = 0x00, candidate = 0x00, stable_cnt = 0, timeout counter = 0, pending = 0, state = IDLE, ser_cs_n = 1, ser_clk = 0, ser_data = 0, busy = 0, synchroniser flops = 1.
REQ-031 Assertion of reset_x mid-frame aborts the frame immediately; no frame is emitted after release until a new commit.

Verification
REQ-032 format_in = 0x01, 4 vsync falling edges -> current_format = 0x01 one cycle after the 4th vs_fall; one frame 0x01FE; ser_cs_n low for 16 x 2 x SCLK_HALF = 800 cycles.
REQ-033 format_in 0x01, 0x01, 0x03, 0x01, 0x01, 0x01 across vsync edges (starting from 0x00) -> no commit before the 6th edge; commit 0x01 only after 4 consecutive matching edges.
REQ-034 current_format = 0x04, vsync held high for VS_TIMEOUT cycles -> current_format = 0x00; frame 0x00FF sent.
REQ-035 Commit 0x02 then 0x0C, then 0x13 while the 0x02 frame is shifting -> frames 0x02FD then 0x13EC only; busy stays high until the second GAP ends.
REQ-036 reset_x pulsed low at bit 7 of a frame -> ser_cs_n = 1 and all outputs at reset values within the same cycle; no further frame until a new commit.
REQ-037 Stable 0x0B recommitted after a timeout-free period -> no extra frame; busy stays 0.
